// File: rtl/store_buffer.sv
// Posted-write store buffer: queues pre-extended store words in FIFO order,
// drains the head to datamemory on drain_en, and forwards to matching loads.
module store_buffer #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [DM_ADDRESS-1:0]   st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic [2:0]              st_func3,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [DM_ADDRESS-1:0]   ld_addr,
    input  logic [2:0]              ld_func3,
    input  logic [DATA_W-1:0]       dm_rd,
    output logic [DATA_W-1:0]       mem_rd,
    output logic                    ld_hit,
    input  logic                    drain_en,
    output logic                    dm_we,
    output logic [DM_ADDRESS-1:0]   dm_a,
    output logic [DATA_W-1:0]       dm_wd,
    output logic [2:0]              dm_func3,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DM_ADDRESS-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     word_q [DEPTH];
    logic [2:0]            f3_q   [DEPTH];

    logic [DEPTH-1:0] vld_q,   vld_d;
    logic [PW-1:0]    head_q,  head_d;
    logic [PW-1:0]    tail_q,  tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic              enq;
    logic              deq;
    logic              probe_hit;
    logic [DATA_W-1:0] probe_word;
    logic [PW-1:0]     probe_idx;

    // Memory image of a store: sub-word stores are sign-extended up front.
    function automatic logic [DATA_W-1:0] store_image(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] d);
        case (f3)
            3'b000:  store_image = {{(DATA_W-8){d[7]}}, d[7:0]};
            3'b001:  store_image = {{(DATA_W-16){d[15]}}, d[15:0]};
            default: store_image = d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_format(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] w);
        case (f3)
            3'b000:  load_format = {{(DATA_W-8){w[7]}}, w[7:0]};
            3'b001:  load_format = {{(DATA_W-16){w[15]}}, w[15:0]};
            3'b100:  load_format = {{(DATA_W-8){1'b0}}, w[7:0]};
            3'b101:  load_format = {{(DATA_W-16){1'b0}}, w[15:0]};
            default: load_format = w;
        endcase
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = !full;

    assign enq = st_valid && !full;
    assign deq = drain_en && !empty;

    always_comb begin
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        if (enq) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            word_q[tail_q] <= store_image(st_func3, st_data);
            f3_q[tail_q]   <= st_func3;
        end
    end

    assign dm_we    = deq;
    assign dm_a     = empty ? '0 : addr_q[head_q];
    assign dm_wd    = empty ? '0 : word_q[head_q];
    assign dm_func3 = empty ? '0 : f3_q[head_q];

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        probe_hit  = 1'b0;
        probe_word = '0;
        probe_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            probe_idx = head_q + PW'(k);
            if (vld_q[probe_idx] && (addr_q[probe_idx] == ld_addr)) begin
                probe_hit  = 1'b1;
                probe_word = word_q[probe_idx];
            end
        end
    end

    assign ld_hit = ld_valid && probe_hit;
    assign mem_rd = ld_hit ? load_format(ld_func3, probe_word) : dm_rd;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DMA   = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           st_valid;
    logic [DMA-1:0] st_addr;
    logic [DW-1:0]  st_data;
    logic [2:0]     st_func3;
    logic           st_ready;
    logic           ld_valid;
    logic [DMA-1:0] ld_addr;
    logic [2:0]     ld_func3;
    logic [DW-1:0]  dm_rd;
    logic [DW-1:0]  mem_rd;
    logic           ld_hit;
    logic           drain_en;
    logic           dm_we;
    logic [DMA-1:0] dm_a;
    logic [DW-1:0]  dm_wd;
    logic [2:0]     dm_func3;
    logic           empty;
    logic           full;
    logic [2:0]     count;

    store_buffer #(.DM_ADDRESS(DMA), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_func3(st_func3), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_func3(ld_func3),
        .dm_rd(dm_rd), .mem_rd(mem_rd), .ld_hit(ld_hit),
        .drain_en(drain_en), .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd),
        .dm_func3(dm_func3), .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DMA-1:0] a;
        logic [DW-1:0]  w;
        logic [2:0]     f;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic [2:0]  sf;
        logic [31:0] sd;
        logic [2:0]  lf;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_image(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'd0) return {{24{d[7]}}, d[7:0]};
        if (f == 3'd1) return {{16{d[15]}}, d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] ref_fmt(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'b0, w[7:0]};
            3'd5:    return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic model_check(input string tag);
        logic        hit;
        logic [31:0] exp_rd;
        int          n;
        n      = q.size();
        hit    = 1'b0;
        exp_rd = dm_rd;
        if (ld_valid) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (q[i].a == ld_addr) begin
                    hit    = 1'b1;
                    exp_rd = ref_fmt(ld_func3, q[i].w);
                    break;
                end
            end
        end
        chk({tag, ".count"},    32'(count),    32'(n));
        chk({tag, ".empty"},    32'(empty),    32'(n == 0));
        chk({tag, ".full"},     32'(full),     32'(n == DEPTH));
        chk({tag, ".st_ready"}, 32'(st_ready), 32'(n != DEPTH));
        chk({tag, ".dm_we"},    32'(dm_we),    32'(drain_en && n > 0));
        chk({tag, ".dm_a"},     32'(dm_a),     (n > 0) ? 32'(q[0].a) : 32'd0);
        chk({tag, ".dm_wd"},    dm_wd,         (n > 0) ? q[0].w : 32'd0);
        chk({tag, ".dm_func3"}, 32'(dm_func3), (n > 0) ? 32'(q[0].f) : 32'd0);
        chk({tag, ".ld_hit"},   32'(ld_hit),   32'(hit));
        chk({tag, ".mem_rd"},   mem_rd,        exp_rd);
    endtask

    // Checks the current cycle against the model, then advances one clock.
    task automatic step(input string tag);
        bit   enq, deq;
        ent_t e;
        #1;
        model_check(tag);
        enq = st_valid && (q.size() < DEPTH) && !reset;
        deq = drain_en && (q.size() > 0) && !reset;
        e.a = st_addr;
        e.w = ref_image(st_func3, st_data);
        e.f = st_func3;
        @(posedge clk);
        #1;
        if (reset) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(e);
        end
    endtask

    task automatic idle();
        st_valid = 0; st_addr = '0; st_data = '0; st_func3 = 3'd2;
        ld_valid = 0; ld_addr = '0; ld_func3 = 3'd2; drain_en = 0;
        dm_rd = 32'h0BAD_F00D;
    endtask

    task automatic push(input logic [DMA-1:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid = 1; st_addr = a; st_data = d; st_func3 = f;
        step("push");
        st_valid = 0;
    endtask

    task automatic drain_all();
        drain_en = 1;
        for (int i = 0; i < DEPTH + 1; i++) step("drain");
        drain_en = 0;
        chk("drain_all.empty", 32'(empty), 32'd1);
    endtask

    initial begin
        idle();
        reset = 1;
        #3;
        chk("rst.empty",    32'(empty),    32'd1);
        chk("rst.full",     32'(full),     32'd0);
        chk("rst.st_ready", 32'(st_ready), 32'd1);
        chk("rst.dm_we",    32'(dm_we),    32'd0);
        chk("rst.dm_a",     32'(dm_a),     32'd0);
        chk("rst.dm_wd",    dm_wd,         32'd0);
        chk("rst.dm_func3", 32'(dm_func3), 32'd0);
        chk("rst.ld_hit",   32'(ld_hit),   32'd0);
        chk("rst.count",    32'(count),    32'd0);
        #5 reset = 0;

        // Enqueue, forward, drain
        push(9'd5, 32'hDEADBEEF, 3'd2);
        #1;
        chk("efd.count", 32'(count), 32'd1);
        chk("efd.empty", 32'(empty), 32'd0);
        ld_valid = 1; ld_addr = 9'd5; ld_func3 = 3'd2;
        #1;
        chk("efd.ld_hit", 32'(ld_hit), 32'd1);
        chk("efd.mem_rd", mem_rd, 32'hDEADBEEF);
        ld_valid = 0; drain_en = 1;
        #1;
        chk("efd.dm_we",    32'(dm_we),    32'd1);
        chk("efd.dm_a",     32'(dm_a),     32'd5);
        chk("efd.dm_wd",    dm_wd,         32'hDEADBEEF);
        chk("efd.dm_func3", 32'(dm_func3), 32'd2);
        step("efd");
        drain_en = 0;
        #1;
        chk("efd.empty_after", 32'(empty), 32'd1);
        chk("efd.we_after",    32'(dm_we), 32'd0);

        // Formatting table: store at addr 3, load back with a given func3
        vecs.push_back('{3'd0, 32'h123456F0, 3'd4, 32'h000000F0});
        vecs.push_back('{3'd0, 32'h123456F0, 3'd0, 32'hFFFFFFF0});
        vecs.push_back('{3'd0, 32'h123456F0, 3'd5, 32'h0000FFF0});
        vecs.push_back('{3'd0, 32'h123456F0, 3'd2, 32'hFFFFFFF0});
        vecs.push_back('{3'd0, 32'h0000007F, 3'd0, 32'h0000007F});
        vecs.push_back('{3'd1, 32'h00018001, 3'd0, 32'h00000001});
        vecs.push_back('{3'd1, 32'h00018001, 3'd1, 32'hFFFF8001});
        vecs.push_back('{3'd1, 32'h00018001, 3'd5, 32'h00008001});
        vecs.push_back('{3'd1, 32'h00018001, 3'd2, 32'hFFFF8001});
        vecs.push_back('{3'd2, 32'h8765A5C3, 3'd0, 32'hFFFFFFC3});
        vecs.push_back('{3'd2, 32'h8765A5C3, 3'd4, 32'h000000C3});
        vecs.push_back('{3'd2, 32'h8765A5C3, 3'd1, 32'hFFFFA5C3});
        vecs.push_back('{3'd2, 32'h8765A5C3, 3'd5, 32'h0000A5C3});
        vecs.push_back('{3'd2, 32'h8765A5C3, 3'd3, 32'h8765A5C3});
        vecs.push_back('{3'd3, 32'hCAFEF00D, 3'd2, 32'hCAFEF00D});
        foreach (vecs[i]) begin
            push(9'd3, vecs[i].sd, vecs[i].sf);
            ld_valid = 1; ld_addr = 9'd3; ld_func3 = vecs[i].lf;
            #1;
            chk($sformatf("tbl%0d.ld_hit", i), 32'(ld_hit), 32'd1);
            chk($sformatf("tbl%0d.mem_rd", i), mem_rd, vecs[i].exp);
            ld_valid = 0;
            drain_all();
        end

        // Youngest match wins; miss passes dm_rd through
        push(9'd7, 32'h11, 3'd2);
        push(9'd7, 32'h22, 3'd2);
        ld_valid = 1; ld_addr = 9'd7; ld_func3 = 3'd2;
        #1;
        chk("young.mem_rd", mem_rd, 32'h22);
        ld_addr = 9'd8; dm_rd = 32'h5555AAAA;
        #1;
        chk("miss.ld_hit", 32'(ld_hit), 32'd0);
        chk("miss.mem_rd", mem_rd, 32'h5555AAAA);
        ld_valid = 0;
        #1;
        chk("noload.mem_rd", mem_rd, 32'h5555AAAA);
        drain_all();

        // Full, ignored fifth push, ordered drain, pointer wrap
        for (int i = 1; i <= 4; i++) push(9'(i), 32'h100 + i, 3'd2);
        #1;
        chk("full.full",     32'(full),     32'd1);
        chk("full.st_ready", 32'(st_ready), 32'd0);
        push(9'd9, 32'h999, 3'd2);
        #1;
        chk("full.count", 32'(count), 32'd4);
        drain_en = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("full.drain%0d", i), 32'(dm_a), 32'(i));
            step("fdrain");
        end
        drain_en = 0;
        push(9'd5, 32'h5, 3'd2);
        push(9'd6, 32'h6, 3'd2);
        drain_en = 1;
        for (int i = 5; i <= 6; i++) begin
            #1;
            chk($sformatf("wrap.drain%0d", i), 32'(dm_a), 32'(i));
            step("wdrain");
        end
        drain_en = 0;
        #1;
        chk("wrap.empty", 32'(empty), 32'd1);

        // Push and drain in the same cycle, load to the draining head
        push(9'd10, 32'hA0, 3'd2);
        push(9'd11, 32'hB0, 3'd2);
        st_valid = 1; st_addr = 9'd12; st_data = 32'hC0; st_func3 = 3'd2;
        drain_en = 1; ld_valid = 1; ld_addr = 9'd10; ld_func3 = 3'd2;
        #1;
        chk("sim.ld_hit", 32'(ld_hit), 32'd1);
        chk("sim.mem_rd", mem_rd, 32'hA0);
        step("sim");
        st_valid = 0; drain_en = 0; ld_valid = 0;
        #1;
        chk("sim.count", 32'(count), 32'd2);
        drain_all();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 9'($urandom_range(0, 7));
            st_data  = $urandom;
            st_func3 = 3'($urandom_range(0, 7));
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = 9'($urandom_range(0, 7));
            ld_func3 = 3'($urandom_range(0, 7));
            drain_en = ($urandom_range(0, 2) == 0);
            dm_rd    = $urandom;
            step("rnd");
        end
        idle();
        drain_all();

        // Asynchronous reset with three pending stores
        for (int i = 0; i < 3; i++) push(9'(20 + i), 32'h300 + i, 3'd2);
        #1;
        chk("arst.pre_count", 32'(count), 32'd3);
        drain_en = 1; ld_valid = 1; ld_addr = 9'd20;
        reset = 1;
        q.delete();
        #1;
        chk("arst.empty",    32'(empty),    32'd1);
        chk("arst.dm_we",    32'(dm_we),    32'd0);
        chk("arst.st_ready", 32'(st_ready), 32'd1);
        chk("arst.ld_hit",   32'(ld_hit),   32'd0);
        step("arst_hold");
        #2 reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("arst.nowrite%0d", i), 32'(dm_we), 32'd0);
            step("arst_after");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM-stage store path and `datamemory`. It accepts stores from the pipeline in one cycle, queues up to DEPTH of them in FIFO order, and drains them to the data memory write port when the hazard/arbitration logic grants `drain_en`. Loads probe the buffer. A load that hits a pending store gets the youngest matching word, formatted exactly as `datamemory` would return it. Otherwise the load receives the memory's own read data.

## Interface
- `DM_ADDRESS`, 9, word-address width (matches `datamemory`)
- `DATA_W`, 32, data width
- `DEPTH`, 4, entry count; power of two, ≥2

Reset is asynchronous and active-high.

- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-high
- `st_valid` in 1: store request from the MEM stage (MemWrite)
- `st_addr` in DM_ADDRESS: store word address
- `st_data` in DATA_W: store data (rs2)
- `st_func3` in 3: store size (000 SB, 001 SH, 010 SW)
- `st_ready` out 1: buffer can accept a store this cycle
- `ld_valid` in 1: load probe (MemRead)
- `ld_addr` in DM_ADDRESS: load word address
- `ld_func3` in 3: load type
- `dm_rd` in DATA_W: read data from `datamemory`
- `mem_rd` out DATA_W: final load data to the MEM/WB register
- `ld_hit` out 1: load was satisfied from the buffer
- `drain_en` in 1: permission to write the head entry this cycle
- `dm_we` out 1: write enable to `datamemory` (drives MemWrite)
- `dm_a` out DM_ADDRESS: write address
- `dm_wd` out DATA_W: write data
- `dm_func3` out 3: write func3
- `empty` out 1: no pending entries
- `full` out 1: count == DEPTH
- `count` out clog2(DEPTH)+1: pending entries

## Operation
- **Storage:** circular array of {addr, word, func3, valid}, with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
- **Enqueue:** on posedge, when `st_valid && st_ready`, write at tail and advance tail.
  - The stored word is the memory image: SB gives {24{st_data[7]}, st_data[7:0]}; SH gives {16{st_data[15]}, st_data[15:0]}; SW and any other func3 give st_data.
  - Raw func3 is kept alongside.
- **`st_ready`:** equals `!full`. A store presented while full is ignored, and the MEM stage must stall on `!st_ready`. A drain in the same cycle does not free a slot for that cycle's store.
- **Drain:** `dm_we = !empty && drain_en`, combinational. `dm_a`, `dm_wd` and `dm_func3` are the head entry fields whenever non-empty, and 0 when empty.
  - When `dm_we` is high, head advances on that posedge, and the memory writes on the same edge.
  - Because the word is pre-extended, re-applying the SB/SH extension in memory yields an identical value.
- **Count update:** count +1 on enqueue only, −1 on drain only, unchanged when both occur.
- **Load probe (combinational):**
  - Compare `ld_addr` against every valid entry, including the head being drained this cycle.
  - `ld_hit = ld_valid && any match`. The youngest match (nearest tail) wins.
  - The forwarded word is formatted by `ld_func3`:
    - 000: {24{w[7]}, w[7:0]}
    - 001: {16{w[15]}, w[15:0]}
    - 010: w
    - 100: {24'b0, w[7:0]}
    - 101: {16'b0, w[15:0]}
    - default: w
  - `mem_rd` = formatted word on hit, else `dm_rd`. `mem_rd = dm_rd` when `!ld_valid`.
- **Simultaneous `st_valid` and `ld_valid`:** the store is enqueued and the load search excludes it. The pipeline never issues both together.

## Timing
- Reset values (asynchronous, immediate): head = tail = count = 0 and all valid bits 0. Outputs are therefore `empty`=1, `full`=0, `st_ready`=1, `dm_we`=0, `dm_a`/`dm_wd`/`dm_func3`=0, `ld_hit`=0.
- Reset mid-operation discards all pending stores. No write is issued.
- Store accepted at edge N is visible to load probes and eligible for drain in cycle N+1. It is written to memory at the first edge ≥N+1 where `drain_en`=1 and it is head.
- Drain rate: at most one entry per cycle. Write order equals enqueue order.
- Load path: zero cycles, purely combinational from `ld_addr`/`ld_func3`/`dm_rd` to `mem_rd`.
- `full`, `empty` and `count` are registered-state derived and glitch-free relative to inputs.

## Test plan
- **Enqueue, forward, drain:** after reset, `drain_en`=0, SW addr 5 data 0xDEADBEEF.
  - Next cycle: `count`=1, `empty`=0.
  - LW addr 5 gives `ld_hit`=1 and `mem_rd`=0xDEADBEEF.
  - Raise `drain_en`: `dm_we`=1, `dm_a`=5, `dm_wd`=0xDEADBEEF, `dm_func3`=010 for one cycle, then `empty`=1.
- **Byte formatting:** SB addr 3 data 0x123456F0 stores word 0xFFFFFFF0.
  - LBU addr 3 gives 0x000000F0.
  - LB gives 0xFFFFFFF0.
  - LHU gives 0x0000FFF0.
- **Youngest wins:** SW addr 7 0x11, then SW addr 7 0x22, `drain_en`=0.
  - LW addr 7 gives 0x22.
  - LW addr 8 gives `ld_hit`=0 and `mem_rd`=`dm_rd`.
- **Full/wrap:** DEPTH=4, `drain_en`=0, push addrs 1,2,3,4.
  - `full`=1, `st_ready`=0. A fifth push (addr 9) is ignored and `count` stays 4.
  - Drain all: `dm_a` sequence is 1,2,3,4. Then push 5,6 so pointers wrap, and they drain in order 5,6.
- **Simultaneous push+drain:** at `count`=2, `count` stays 2. A load to the draining head address still hits in that cycle.
- **Async reset mid-operation:** reset asserted with `count`=3.
  - Immediately: `empty`=1, `dm_we`=0, `st_ready`=1, `ld_hit`=0.
  - No memory write occurs after reset.
